// File: rtl/arith_result_serializer_pkg.sv
// Shared constants and helpers for the arithmetic result serializer.
// State encoding, byte width and the bytes-per-result derivation live here.
package arith_result_serializer_pkg;

  localparam int BYTE_W = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  function automatic int nbytes_of(input int width);
    return (2 * width) / BYTE_W;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Single-clock result FIFO with full/empty/count status.
// The head word is read from registered storage and captured by the consumer on pop.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arith_result_serializer.sv
// Buffers valid arithmetic results and streams each one out MSB-first as bytes
// over a valid/ready handshake, flagging dropped results with a sticky overflow.
module arith_result_serializer
  import arith_result_serializer_pkg::*;
#(
  parameter int width = 16,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [2*width-1:0]     Arith_Out,
  input  logic                   Arith_Flag,
  input  logic                   Clr_Overflow,
  input  logic                   Out_Ready,
  output logic [BYTE_W-1:0]      Out_Data,
  output logic                   Out_Valid,
  output logic                   Out_Last,
  output logic                   Overflow,
  output logic [$clog2(DEPTH):0] Fifo_Count
);

  localparam int RW     = 2 * width;
  localparam int NBYTES = nbytes_of(width);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic             state;
  logic             next_state;
  logic             pop;
  logic             at_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic [RW-1:0]    fifo_head;
  logic [RW-1:0]    shift_reg;
  logic [IDX_W-1:0] byte_idx;
  logic             drop;

  result_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (Arith_Flag),
    .push_data (Arith_Out),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (Fifo_Count)
  );

  assign at_last = (byte_idx == LAST_IDX);
  assign drop    = Arith_Flag && fifo_full && !pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Popping on the last accepted byte keeps consecutive results gap-free.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Out_Ready && at_last) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    Out_Valid = (state == ST_SEND);
    Out_Data  = Out_Valid ? shift_reg[RW-1 -: BYTE_W] : '0;
    Out_Last  = Out_Valid && at_last;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      byte_idx  <= '0;
    end else if (pop) begin
      shift_reg <= fifo_head;
      byte_idx  <= '0;
    end else if ((state == ST_SEND) && Out_Ready && !at_last) begin
      shift_reg <= shift_reg << BYTE_W;
      byte_idx  <= byte_idx + 1'b1;
    end
  end

  // A drop and a clear on the same edge leave the flag set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Overflow <= 1'b0;
    end else if (drop) begin
      Overflow <= 1'b1;
    end else if (Clr_Overflow) begin
      Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_result_serializer.sv
// Self-checking bench for arith_result_serializer: vector table, directed corner
// sequences and randomized traffic against a queue-level reference model.
module tb_arith_result_serializer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int NB    = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Arith_Out;
  logic        Arith_Flag;
  logic        Clr_Overflow;
  logic        Out_Ready;
  logic [7:0]  Out_Data;
  logic        Out_Valid;
  logic        Out_Last;
  logic        Overflow;
  logic [2:0]  Fifo_Count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          m_busy;
  int          m_rem;
  logic [31:0] m_cur;
  bit          m_ovf;

  logic [7:0]  got[$];
  int          cyc;
  int          peak;
  int          vcount;
  int          first_v;
  int          last_v;

  typedef struct {
    logic        flag;
    logic [31:0] data;
    logic        ready;
    logic        valid;
    logic [7:0]  dat;
    logic        last;
    int          count;
  } vec_t;

  vec_t tbl[7];

  arith_result_serializer #(
    .width (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Arith_Out    (Arith_Out),
    .Arith_Flag   (Arith_Flag),
    .Clr_Overflow (Clr_Overflow),
    .Out_Ready    (Out_Ready),
    .Out_Data     (Out_Data),
    .Out_Valid    (Out_Valid),
    .Out_Last     (Out_Last),
    .Overflow     (Overflow),
    .Fifo_Count   (Fifo_Count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelClear();
    mq.delete();
    m_busy = 1'b0;
    m_rem  = 0;
    m_cur  = '0;
    m_ovf  = 1'b0;
    got.delete();
  endtask

  task automatic checkOutput();
    logic [7:0] ed;
    ed = m_busy ? 8'(m_cur >> (8 * (m_rem - 1))) : 8'h00;
    check("valid",    32'(Out_Valid),  32'(m_busy));
    check("data",     32'(Out_Data),   32'(ed));
    check("last",     32'(Out_Last),   32'(m_busy && (m_rem == 1)));
    check("count",    32'(Fifo_Count), 32'(mq.size()));
    check("overflow", 32'(Overflow),   32'(m_ovf));
  endtask

  // Drives one cycle of inputs, compares outputs with the model, then advances model and clock.
  task automatic applyStimulus(input logic flag, input logic [31:0] data, input logic ready, input logic clr);
    bit hs, pop, full, drop;
    Arith_Flag   = flag;
    Arith_Out    = data;
    Out_Ready    = ready;
    Clr_Overflow = clr;
    checkOutput();
    if (Out_Valid && ready) got.push_back(Out_Data);
    if (Out_Valid) begin
      vcount++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (32'(Fifo_Count) > peak) peak = 32'(Fifo_Count);
    hs   = m_busy && ready;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() > 0) && (!m_busy || (hs && m_rem == 1));
    drop = flag && full && !pop;
    if (hs) begin
      m_rem--;
      if (m_rem == 0) m_busy = 1'b0;
    end
    if (pop) begin
      m_cur  = mq.pop_front();
      m_busy = 1'b1;
      m_rem  = NB;
    end
    if (flag && !drop) mq.push_back(data);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((m_busy || mq.size() > 0 || Out_Valid) && n < maxc) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic checkWords(input string name, input logic [31:0] words[$]);
    check({name, "_len"}, 32'(got.size()), 32'(words.size() * NB));
    for (int j = 0; j < words.size(); j++) begin
      for (int b = 0; b < NB; b++) begin
        if (j * NB + b < got.size())
          check(name, 32'(got[j*NB+b]), 32'(8'(words[j] >> (8 * (NB - 1 - b)))));
      end
    end
  endtask

  initial begin
    logic [31:0] words[$];
    logic        rp[4];
    int          n;

    RST = 1'b0; Arith_Flag = 1'b0; Arith_Out = '0; Clr_Overflow = 1'b0; Out_Ready = 1'b0;
    cyc = 0; peak = 0; vcount = 0; first_v = -1; last_v = -1;
    modelClear();
    @(posedge CLK);
    #1;
    checkOutput();
    RST = 1'b1;

    // Single result, with the table holding the exact expected waveform.
    tbl[0] = '{1'b1, 32'h12345678, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    tbl[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1};
    tbl[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h12, 1'b0, 0};
    tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h34, 1'b0, 0};
    tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h56, 1'b0, 0};
    tbl[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h78, 1'b1, 0};
    tbl[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 0};
    for (int i = 0; i < 7; i++) begin
      check("tbl_valid", 32'(Out_Valid),  32'(tbl[i].valid));
      check("tbl_data",  32'(Out_Data),   32'(tbl[i].dat));
      check("tbl_last",  32'(Out_Last),   32'(tbl[i].last));
      check("tbl_count", 32'(Fifo_Count), 32'(tbl[i].count));
      applyStimulus(tbl[i].flag, tbl[i].data, tbl[i].ready, 1'b0);
    end

    // Negative value under a 1,0,0,1 ready pattern.
    got.delete();
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b1, 32'hFFFFFFFD, 1'b1, 1'b0);
    n = 0;
    while (got.size() < NB && n < 40) begin
      applyStimulus(1'b0, 32'h0, rp[n % 4], 1'b0);
      n++;
    end
    words = '{32'hFFFFFFFD};
    checkWords("neg_bytes", words);
    drain(20);

    // Three back-to-back results must stream without a valid gap.
    got.delete(); peak = 0; vcount = 0; first_v = -1; last_v = -1;
    applyStimulus(1'b1, 32'h11111111, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h22222222, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h33333333, 1'b1, 1'b0);
    drain(30);
    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    checkWords("b2b_bytes", words);
    check("b2b_span",   32'(last_v - first_v + 1), 32'd12);
    check("b2b_vcount", 32'(vcount), 32'd12);
    check("b2b_peak",   32'(peak),   32'd2);

    // Overflow with a stalled consumer, then clear colliding with a new drop.
    got.delete();
    for (int v = 1; v <= 6; v++) applyStimulus(1'b1, 32'(v), 1'b0, 1'b0);
    check("ovf_set",   32'(Overflow),   32'd1);
    check("ovf_count", 32'(Fifo_Count), 32'd4);
    applyStimulus(1'b1, 32'd7, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(Overflow), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    check("ovf_cleared",  32'(Overflow), 32'd0);
    drain(40);
    words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    checkWords("ovf_bytes", words);

    // Push into a full FIFO on the same edge as the final byte's pop.
    got.delete();
    for (int v = 1; v <= 5; v++) applyStimulus(1'b1, 32'h100 + 32'(v), 1'b0, 1'b0);
    check("full_count", 32'(Fifo_Count), 32'd4);
    n = 0;
    while (!(m_busy && m_rem == 1) && n < 20) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      n++;
    end
    check("full_reach_last", 32'(n < 20), 32'd1);
    applyStimulus(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    check("full_pushpop_count", 32'(Fifo_Count), 32'd4);
    check("full_pushpop_ovf",   32'(Overflow),   32'd0);
    drain(40);
    words = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'hA5A5A5A5};
    checkWords("full_bytes", words);

    // Asynchronous reset in the middle of a transfer with results queued.
    got.delete();
    applyStimulus(1'b1, 32'hAABBCCDD, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h01020304, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h05060708, 1'b0, 1'b0);
    n = 0;
    while (got.size() < 2 && n < 20) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      n++;
    end
    check("rst_pre_bytes", 32'(got.size()), 32'd2);
    #2;
    RST = 1'b0;
    #1;
    check("rst_valid", 32'(Out_Valid),  32'd0);
    check("rst_data",  32'(Out_Data),   32'd0);
    check("rst_last",  32'(Out_Last),   32'd0);
    check("rst_ovf",   32'(Overflow),   32'd0);
    check("rst_count", 32'(Fifo_Count), 32'd0);
    modelClear();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    applyStimulus(1'b1, 32'h0F1E2D3C, 1'b1, 1'b0);
    drain(20);
    words = '{32'h0F1E2D3C};
    checkWords("rst_after", words);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 99) < 70,
                    $urandom_range(0, 99) < 5);
    end
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
